osd_vram_ctrl: RTL
==================

// Module: osd_vram_ctrl
// PURPOSE
//   Sequences writes into the OSD character/attribute video RAM from 16-bit OSD commands decoded off the MCU SPI link.
//   Holds the text cursor, current attribute and OSD enable, and runs multi-cycle screen clears.
//   Sits between the MCU command decoder and the OSD overlay's VRAM write port; the overlay reads VRAM on its own port.
// PARAMETERS
//   COLS      32     characters per row
//   ROWS      24     rows per screen
//   ADDR_W    10     VRAM address width; 2**ADDR_W >= COLS*ROWS
//   DEF_ATTR  8'h0F  attribute after reset
// PORTS
//   clk         in   1       system clock; all logic on posedge
//   rst_n       in   1       asynchronous, active-low reset
//   cmd_valid   in   1       1-cycle strobe: cmd holds a new OSD command
//   cmd         in   16      [15:8] opcode, [7:0] argument
//   vram_we     out  1       VRAM write enable, one cell per cycle
//   vram_addr   out  ADDR_W  cell address = row*COLS + col
//   vram_wdata  out  16      {attr[7:0], char[7:0]}
//   osd_en      out  1       overlay display enable
//   busy        out  1       high while CLEAR runs or a command is pending
//   cmd_drop    out  1       1-cycle pulse: command lost (buffer full)
// BEHAVIOUR
//   Reset: vram_we=0, vram_addr=0, vram_wdata=0, osd_en=0, busy=0, cmd_drop=0; col=row=0; attr=DEF_ATTR; FSM=IDLE; pending empty.
//   Opcodes (unlisted opcodes ignored, no state change):
//     8'h01 SET_X    col <= min(arg, COLS-1)
//     8'h02 SET_Y    row <= min(arg, ROWS-1)
//     8'h03 SET_ATTR attr <= arg
//     8'h04 PUT_CHR  write {attr,arg} at (col,row), then advance cursor
//     8'h05 CLEAR    fill all cells with {attr,8'h20}; cursor <= (0,0)
//     8'h06 OSD_EN   osd_en <= arg[0]
//   FSM states: IDLE, CLEAR.
//     IDLE: command accepted on the cmd_valid edge; register effects visible next cycle.
//       PUT_CHR: vram_we=1 exactly one cycle, the cycle after the accepting edge; addr/wdata valid in that cycle.
//       CLEAR: -> CLEAR; busy=1 from the next cycle.
//     CLEAR: vram_we=1 for COLS*ROWS consecutive cycles, addr 0..COLS*ROWS-1 ascending.
//       After last cell: -> IDLE; cursor=(0,0); busy=0 unless pending full.
//   Cursor advance: col+1; col==COLS-1 -> col=0, row+1; row==ROWS-1 at that point -> row=0 (wrap to top).
//   Pending buffer: 1 entry, filled only when cmd_valid arrives during CLEAR.
//     Executed in the first IDLE cycle after CLEAR; that cycle counts as its accept edge.
//     cmd_valid in IDLE while pending full: pending runs first; the new command is stored in its place, not dropped.
//     cmd_valid with the buffer full during CLEAR: new command dropped, cmd_drop=1 for one cycle; the stored command is kept.
//   SET_ATTR pending behind CLEAR does not affect the running fill.
//     CLEAR latches attr at its start.
//   vram_we is never high outside PUT_CHR or CLEAR cycles; vram_addr < COLS*ROWS whenever vram_we=1.
//   busy = (FSM==CLEAR) | pending_full.
//   rst_n low mid-CLEAR aborts immediately.
//     Outputs go to reset values; the partial fill is not completed.
//   Address arithmetic: row*COLS+col with COLS a constant; result truncated to ADDR_W.
//     Clear counter is ADDR_W+1 bits so ROWS*COLS == 2**ADDR_W terminates correctly.
// STRUCTURE
//   Shared package osd_pkg:
//     opcode localparams (OSD_SET_X..OSD_EN)
//     blank char 8'h20
//     FSM state encoding, shared with the verification bench
//   Single module; no sub-module.
//     The 1-entry pending register is small enough to stay inline.
// TESTING
//   1. Reset then idle: all outputs at reset values, no vram_we for 100 cycles.
//   2. SET_X 3, SET_Y 2, SET_ATTR 8'h4E, PUT_CHR 8'h41:
//      one vram_we, addr=67, wdata=16'h4E41; cursor then (4,2).
//   3. Cursor at (31,23), PUT_CHR 8'h5A: write at addr 767; cursor wraps to (0,0).
//      A further PUT_CHR writes addr 0.
//   4. CLEAR with attr 8'h07: 768 consecutive writes, addr 0..767, wdata=16'h0720.
//      busy high throughout; busy low one cycle after the last write.
//   5. During CLEAR send OSD_EN 1 then SET_X 5:
//      OSD_EN buffered; SET_X gives cmd_drop pulse; after CLEAR, osd_en=1 and col=0.
//   6. SET_X 8'hFF -> col=31. Unknown opcode 8'h7F -> no change.
//      rst_n low at clear cell 100 -> vram_we=0 at once; state back to reset.

Source files
------------

// File: rtl/osd_pkg.sv
// osd_pkg: OSD command opcodes, blank character and FSM state encoding shared by RTL and bench
package osd_pkg;
    localparam logic [7:0] OSD_SET_X    = 8'h01;
    localparam logic [7:0] OSD_SET_Y    = 8'h02;
    localparam logic [7:0] OSD_SET_ATTR = 8'h03;
    localparam logic [7:0] OSD_PUT_CHR  = 8'h04;
    localparam logic [7:0] OSD_CLEAR    = 8'h05;
    localparam logic [7:0] OSD_EN       = 8'h06;
    localparam logic [7:0] BLANK_CHR    = 8'h20;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
endpackage

// File: rtl/osd_vram_ctrl.sv
// osd_vram_ctrl: turns OSD commands into VRAM cell writes, keeps cursor/attr/enable, runs screen clears
module osd_vram_ctrl
    import osd_pkg::*;
#(
    parameter int         COLS     = 32,
    parameter int         ROWS     = 24,
    parameter int         ADDR_W   = 10,
    parameter logic [7:0] DEF_ATTR = 8'h0F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [15:0]       cmd,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [15:0]       vram_wdata,
    output logic              osd_en,
    output logic              busy,
    output logic              cmd_drop
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [ADDR_W:0] N_CELLS = (ADDR_W+1)'(COLS*ROWS);

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [7:0]        attr;
    logic [7:0]        clr_attr;
    logic [ADDR_W:0]   clr_cnt;
    logic              pend_full;
    logic [15:0]       pend_cmd;
    logic              exec_v;
    logic [15:0]       exec_cmd;
    logic [ADDR_W-1:0] cur_addr;

    // A stored command always runs before a freshly arriving one
    assign exec_v   = pend_full | cmd_valid;
    assign exec_cmd = pend_full ? pend_cmd : cmd;
    assign cur_addr = ADDR_W'(32'(row) * COLS + 32'(col));
    assign busy     = (state == ST_CLEAR) | pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            attr       <= DEF_ATTR;
            clr_attr   <= DEF_ATTR;
            clr_cnt    <= '0;
            pend_full  <= 1'b0;
            pend_cmd   <= '0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            osd_en     <= 1'b0;
            cmd_drop   <= 1'b0;
        end else begin
            vram_we  <= 1'b0;
            cmd_drop <= 1'b0;
            if (state == ST_CLEAR) begin
                if (cmd_valid) begin
                    if (pend_full) cmd_drop <= 1'b1;
                    else begin
                        pend_full <= 1'b1;
                        pend_cmd  <= cmd;
                    end
                end
                if (clr_cnt == N_CELLS) begin
                    state <= ST_IDLE;
                    col   <= '0;
                    row   <= '0;
                end else begin
                    vram_we    <= 1'b1;
                    vram_addr  <= clr_cnt[ADDR_W-1:0];
                    vram_wdata <= {clr_attr, BLANK_CHR};
                    clr_cnt    <= clr_cnt + 1'b1;
                end
            end else if (exec_v) begin
                pend_full <= pend_full & cmd_valid;
                if (pend_full && cmd_valid) pend_cmd <= cmd;
                case (exec_cmd[15:8])
                    OSD_SET_X:    col  <= (32'(exec_cmd[7:0]) > COLS-1) ? CW'(COLS-1) : CW'(exec_cmd[7:0]);
                    OSD_SET_Y:    row  <= (32'(exec_cmd[7:0]) > ROWS-1) ? RW'(ROWS-1) : RW'(exec_cmd[7:0]);
                    OSD_SET_ATTR: attr <= exec_cmd[7:0];
                    OSD_EN:       osd_en <= exec_cmd[0];
                    OSD_PUT_CHR: begin
                        vram_we    <= 1'b1;
                        vram_addr  <= cur_addr;
                        vram_wdata <= {attr, exec_cmd[7:0]};
                        if (col == CW'(COLS-1)) begin
                            col <= '0;
                            row <= (row == RW'(ROWS-1)) ? '0 : row + 1'b1;
                        end else col <= col + 1'b1;
                    end
                    OSD_CLEAR: begin
                        // First cell is written from the accepting edge so the fill is back-to-back
                        state      <= ST_CLEAR;
                        clr_attr   <= attr;
                        vram_we    <= 1'b1;
                        vram_addr  <= '0;
                        vram_wdata <= {attr, BLANK_CHR};
                        clr_cnt    <= (ADDR_W+1)'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
